// File: rtl/shared_eva_remote_req_stage.sv
// shared_eva_remote_req_stage
//
// Pipeline stage between the core's shared-EVA memory request and the remote
// packet launcher. A tile-group shared EVA is split by the stripe hash into a
// local tile X/Y and a word offset. The tile-group origin is added to the
// local coordinates, and the result is range-checked. The request is then
// held in a two-entry skid buffer. The buffer presents a registered request
// downstream and drives a registered ready_o.
//
// Optional build macro: SHARED_EVA_ERR_DROP_EN
//   defined   : erroneous requests are accepted but dropped (never reach v_o).
//               err_count_o counts them, saturating at 0xFFFF. err_o is 0.
//   undefined : erroneous requests are forwarded with err_o = 1.
//               err_count_o is 0.
//
// Handshake (both sides): a transfer happens on a rising clock edge where
// valid and ready are both high. Once the producer raises valid, it holds
// valid high and keeps the payload stable until that transfer.
//
// Ports:
//   clk_i, reset_i                 clock, synchronous active-high reset
//   v_i / ready_o                  upstream request handshake
//   shared_eva_i, hash_i           shared EVA and stripe hash (log2 words)
//   we_i, data_i, mask_i           store payload (passed through)
//   tg_origin_x_i, tg_origin_y_i   tile-group origin (quasi-static)
//   tg_dim_x_i, tg_dim_y_i         tile-group dimensions
//   v_o / ready_i                  downstream request handshake
//   x_o, y_o, addr_o               destination tile and local word address
//   we_o, data_o, mask_o           payload passthrough
//   err_o                          request is out of range
//   err_count_o                    dropped-error counter

module shared_eva_remote_req_stage #(
    parameter int width_p         = 32,
    parameter int x_cord_width_p  = 7,
    parameter int y_cord_width_p  = 7,
    parameter int x_local_width_p = 2,
    parameter int y_local_width_p = 2,
    parameter int hash_width_p    = 4,
    parameter int addr_width_p    = 12,
    parameter int data_width_p    = 32
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         v_i,
    output logic                         ready_o,
    input  logic [width_p-1:0]           shared_eva_i,
    input  logic [hash_width_p-1:0]      hash_i,
    input  logic                         we_i,
    input  logic [data_width_p-1:0]      data_i,
    input  logic [data_width_p/8-1:0]    mask_i,
    input  logic [x_cord_width_p-1:0]    tg_origin_x_i,
    input  logic [y_cord_width_p-1:0]    tg_origin_y_i,
    input  logic [x_local_width_p:0]     tg_dim_x_i,
    input  logic [y_local_width_p:0]     tg_dim_y_i,
    output logic                         v_o,
    input  logic                         ready_i,
    output logic [x_cord_width_p-1:0]    x_o,
    output logic [y_cord_width_p-1:0]    y_o,
    output logic [addr_width_p-1:0]     addr_o,
    output logic                         we_o,
    output logic [data_width_p-1:0]      data_o,
    output logic [data_width_p/8-1:0]    mask_o,
    output logic                         err_o,
    output logic [15:0]                  err_count_o
);

    localparam int mask_width_lp = data_width_p / 8;

    typedef struct packed {
        logic [x_cord_width_p-1:0] x;
        logic [y_cord_width_p-1:0] y;
        logic [addr_width_p-1:0]   addr;
        logic                      we;
        logic [data_width_p-1:0]   data;
        logic [mask_width_lp-1:0]  mask;
        logic                      err;
    } req_s;

    // The state encodes the occupancy: EMPTY = 0, ONE = 1, TWO = 2 entries.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    // EVA bit lookup. Any index past the top of the EVA reads as 0, and a
    // right shift gives that for free.
    function automatic logic eva_bit(input logic [width_p-1:0] eva, input int idx);
        logic [width_p-1:0] sh;
        sh = eva >> idx;
        return sh[0];
    endfunction

    // ---------------------------------------------------------------- decode
    logic [x_local_width_p-1:0] x_local;
    logic [y_local_width_p-1:0] y_local;
    logic [addr_width_p-1:0]    dec_addr;
    logic [x_cord_width_p-1:0]  x_glob;
    logic [y_cord_width_p-1:0]  y_glob;
    logic                       hash_oob;
    logic                       in_err;
    req_s                       in_req;

    // Layout from the LSB: hash_i offset bits, then local X, then local Y,
    // then the remaining offset bits. The address is the EVA with the X/Y
    // field squeezed out.
    always_comb begin
        x_local  = '0;
        y_local  = '0;
        dec_addr = '0;
        for (int j = 0; j < x_local_width_p; j++)
            x_local[j] = eva_bit(shared_eva_i, int'(hash_i) + j);
        for (int j = 0; j < y_local_width_p; j++)
            y_local[j] = eva_bit(shared_eva_i, int'(hash_i) + x_local_width_p + j);
        for (int i = 0; i < addr_width_p; i++)
            dec_addr[i] = (i < int'(hash_i))
                        ? eva_bit(shared_eva_i, i)
                        : eva_bit(shared_eva_i, i + x_local_width_p + y_local_width_p);
    end

    assign hash_oob = (int'(hash_i) > addr_width_p);
    assign x_glob   = tg_origin_x_i + x_cord_width_p'(x_local);
    assign y_glob   = tg_origin_y_i + y_cord_width_p'(y_local);
    assign in_err   = hash_oob
                    | ({1'b0, x_local} >= tg_dim_x_i)
                    | ({1'b0, y_local} >= tg_dim_y_i);

    always_comb begin
        in_req      = '0;
        in_req.x    = hash_oob ? '0 : x_glob;
        in_req.y    = hash_oob ? '0 : y_glob;
        in_req.addr = hash_oob ? '0 : dec_addr;
        in_req.we   = we_i;
        in_req.data = data_i;
        in_req.mask = mask_i;
`ifdef SHARED_EVA_ERR_DROP_EN
        in_req.err  = 1'b0;
`else
        in_req.err  = in_err;
`endif
    end

    // ------------------------------------------------------------ handshake
    logic ready_q;
    logic accept;
    logic load;
    logic out_xfer;

    assign ready_o  = ready_q & ~reset_i;
    assign accept   = v_i & ready_o;
    assign out_xfer = v_o & ready_i;

`ifdef SHARED_EVA_ERR_DROP_EN
    // An erroneous request still consumes the handshake. It never reaches
    // storage.
    assign load = accept & ~in_err;

    logic [15:0] err_count_q;
    always_ff @(posedge clk_i) begin
        if (reset_i)
            err_count_q <= '0;
        else if (accept && in_err && (err_count_q != 16'hFFFF))
            err_count_q <= err_count_q + 16'd1;
    end
    assign err_count_o = err_count_q;
`else
    assign load        = accept;
    assign err_count_o = '0;
`endif

    // ---------------------------------------------------------- skid buffer
    state_e state_q, state_n;
    req_s   main_q, skid_q;
    logic   load_main, load_skid, main_from_skid;

    always_comb begin
        state_n        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (load) begin
                    state_n   = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (load && !out_xfer) begin
                    state_n   = TWO;
                    load_skid = 1'b1;
                end else if (load && out_xfer) begin
                    load_main = 1'b1;
                end else if (out_xfer) begin
                    state_n = EMPTY;
                end
            end
            TWO: begin
                // ready_o is low here, so only the drain can happen.
                if (out_xfer) begin
                    state_n        = ONE;
                    main_from_skid = 1'b1;
                end
            end
            default: state_n = EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= EMPTY;
            ready_q <= 1'b1;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_n;
            // The register holds "next occupancy != 2". Because ready_o
            // comes straight from this register, it never depends on
            // ready_i combinationally.
            ready_q <= (state_n != TWO);
            if (load_main)
                main_q <= in_req;
            else if (main_from_skid)
                main_q <= skid_q;
            if (load_skid)
                skid_q <= in_req;
        end
    end

    assign v_o    = (state_q != EMPTY);
    assign x_o    = main_q.x;
    assign y_o    = main_q.y;
    assign addr_o = main_q.addr;
    assign we_o   = main_q.we;
    assign data_o = main_q.data;
    assign mask_o = main_q.mask;
    assign err_o  = main_q.err;

endmodule
